// File: rtl/bcd_updown_counter.sv
// Modulo-(MAX_COUNT+1) up/down counter with load, terminal count and wrap pulse.
// Define BCD_COUNTER_GRAY_OUT_EN to add a registered Gray-coded copy of count.
module bcd_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
`ifdef BCD_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] gray
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (up) begin
        if (count_q < MAX_V) begin
          count_d = count_q + 1'b1;
        end else if (count_q == MAX_V) begin
          if (SATURATE == 0) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          // Out-of-range state recovers to zero without flagging a wrap.
          count_d = '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else if (SATURATE == 0) begin
          count_d = MAX_V;
          wrap_d  = 1'b1;
        end
      end
    end
  end

`ifdef BCD_COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_q;

  // Gray is derived from count_d so it changes on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= count_d ^ (count_d >> 1);
    end
  end

  assign gray = gray_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign tc    = en & ((up & (count_q == MAX_V)) | (~up & (count_q == '0)));

endmodule
